// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, frame constants and baud divisor helpers.
// Used by both the receive path and the transmit chain.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int FRAME_DBITS = 8;
  localparam int STOP_BITS   = 1;

  function automatic int baud_div(input int sclk, input int baud);
    return sclk / baud;
  endfunction

  function automatic int baud_half(input int sclk, input int baud);
    return (sclk / baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_baud.sv
// Receive baud counter: free-runs while enabled, strobes at the half-bit point
// in half_sel mode (start-bit centring) and at the full bit period otherwise.
module uart_rx_baud #(
  parameter int DIV  = 434,
  parameter int HALF = 217
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic half_sel,
  output logic strobe
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  assign strobe = ~clr && (cnt == (half_sel ? CW'(HALF - 1) : CW'(DIV - 1)));

  // Wrapping on the strobe re-centres every subsequent sample on mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (clr || strobe) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronises iRX, finds the start edge, samples mid-bit
// LSB-first and reports each frame as a one-cycle valid or framing-error pulse.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int SCYCLE   = 50000000,
  parameter int BAUDRATE = 115200,
  parameter int DWIDTH   = FRAME_DBITS
) (
  input  logic              iCLOCK,
  input  logic              iRESET,
  input  logic              iRX,
  output logic [DWIDTH-1:0] oRXDATA,
  output logic              oRXVALID,
  output logic              oRXBUSY,
  output logic              oFRAMEERR,
  output logic [1:0]        oSTATE
);

  localparam int DIV  = baud_div(SCYCLE, BAUDRATE);
  localparam int HALF = baud_half(SCYCLE, BAUDRATE);
  localparam int BW   = $clog2(DWIDTH);

  uart_state_t       state;
  logic              rx_s1, rx_s2, rx_prev;
  logic [BW-1:0]     idx;
  logic [DWIDTH-1:0] shreg;
  logic              strobe;
  logic              fall;

  assign fall = rx_prev & ~rx_s2;

  uart_rx_baud #(
    .DIV  (DIV),
    .HALF (HALF)
  ) u_baud (
    .clk      (iCLOCK),
    .rst      (iRESET),
    .clr      (state == IDLE),
    .half_sel (state == START),
    .strobe   (strobe)
  );

  // Synchroniser idles high so reset release never looks like a start edge.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= IDLE;
      idx       <= '0;
      shreg     <= '0;
      oRXDATA   <= '0;
      oRXVALID  <= 1'b0;
      oFRAMEERR <= 1'b0;
    end else begin
      rx_s1     <= iRX;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_s2;
      oRXVALID  <= 1'b0;
      oFRAMEERR <= 1'b0;
      case (state)
        IDLE: if (fall) state <= START;
        START: if (strobe) begin
          idx   <= '0;
          state <= rx_s2 ? IDLE : DATA;
        end
        DATA: if (strobe) begin
          shreg[idx] <= rx_s2;
          if (idx == BW'(DWIDTH - 1)) state <= STOP;
          else                        idx   <= idx + 1'b1;
        end
        STOP: if (strobe) begin
          // Leaving at mid-stop lets a zero-gap next start edge be caught.
          if (rx_s2) begin
            oRXDATA  <= shreg;
            oRXVALID <= 1'b1;
          end else begin
            oFRAMEERR <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oRXBUSY = (state != IDLE);
  assign oSTATE  = state;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of single frames plus hand-written
// back-to-back, glitch, framing-error, mid-frame reset and random-burst sequences.
module tb_uart_receiver;

  localparam int BIT = 434;
  localparam int LAT = 4126;

  logic       iCLOCK, iRESET, iRX;
  logic [7:0] oRXDATA;
  logic       oRXVALID, oRXBUSY, oFRAMEERR;
  logic [1:0] oSTATE;

  uart_receiver dut (
    .iCLOCK    (iCLOCK),
    .iRESET    (iRESET),
    .iRX       (iRX),
    .oRXDATA   (oRXDATA),
    .oRXVALID  (oRXVALID),
    .oRXBUSY   (oRXBUSY),
    .oFRAMEERR (oFRAMEERR),
    .oSTATE    (oSTATE)
  );

  initial iCLOCK = 1'b0;
  always #10 iCLOCK = ~iCLOCK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int vcnt = 0, fcnt = 0, both = 0, last_vcyc = 0;
  logic [7:0] rxq[$];

  always @(posedge iCLOCK) cyc <= cyc + 1;

  always @(negedge iCLOCK) begin
    if (!iRESET) begin
      if (oRXVALID) begin
        vcnt++;
        last_vcyc = cyc;
        rxq.push_back(oRXDATA);
      end
      if (oFRAMEERR) fcnt++;
      if (oRXVALID && oFRAMEERR) both++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp, input int tol = 0);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  task automatic drive(input logic v, input int n);
    iRX = v;
    repeat (n) @(negedge iCLOCK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopv, input int bc);
    drive(1'b0, bc);
    for (int b = 0; b < 8; b++) drive(d[b], bc);
    drive(stopv, bc);
  endtask

  typedef struct {
    logic [7:0] data;
    int         bitc;
    int         exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vt[3];
  int   v0, f0, c0;
  logic [7:0] rnd[5];

  initial begin
    // data, cycles per bit (nominal, -2 %, +2 %), expected pulses, expected byte
    vt[0] = '{8'h55, 434, 1, 8'h55};
    vt[1] = '{8'h96, 425, 1, 8'h96};
    vt[2] = '{8'h69, 443, 1, 8'h69};

    iRESET = 1'b1;
    iRX    = 1'b1;
    repeat (3) @(negedge iCLOCK);
    chk("reset_data",  int'(oRXDATA), 0);
    chk("reset_valid", int'(oRXVALID), 0);
    chk("reset_busy",  int'(oRXBUSY), 0);
    chk("reset_ferr",  int'(oFRAMEERR), 0);
    chk("reset_state", int'(oSTATE), 0);
    iRESET = 1'b0;
    repeat (20) @(negedge iCLOCK);

    // single frames from the table, including baud drift
    for (int i = 0; i < 3; i++) begin
      v0 = vcnt; f0 = fcnt; c0 = cyc;
      send_frame(vt[i].data, 1'b1, vt[i].bitc);
      drive(1'b1, 50);
      chk($sformatf("tbl%0d_valid", i), vcnt - v0, vt[i].exp_valid);
      chk($sformatf("tbl%0d_ferr", i),  fcnt - f0, 0);
      chk($sformatf("tbl%0d_data", i),  int'(oRXDATA), int'(vt[i].exp_data));
      chk($sformatf("tbl%0d_lat", i),   last_vcyc - c0, LAT, 2);
    end

    // back-to-back frames, zero idle gap
    rxq.delete();
    v0 = vcnt;
    send_frame(8'hA3, 1'b1, BIT);
    send_frame(8'h00, 1'b1, BIT);
    send_frame(8'hFF, 1'b1, BIT);
    drive(1'b1, 50);
    chk("b2b_count", vcnt - v0, 3);
    chk("b2b_d0", rxq.size() > 0 ? int'(rxq.pop_front()) : -1, 'hA3);
    chk("b2b_d1", rxq.size() > 0 ? int'(rxq.pop_front()) : -1, 'h00);
    chk("b2b_d2", rxq.size() > 0 ? int'(rxq.pop_front()) : -1, 'hFF);

    // glitch: short low pulse is rejected at the half-bit sample
    v0 = vcnt; f0 = fcnt;
    drive(1'b0, 100);
    chk("glitch_state_start", int'(oSTATE), 1);
    chk("glitch_busy", int'(oRXBUSY), 1);
    drive(1'b1, 300);
    chk("glitch_state_idle", int'(oSTATE), 0);
    chk("glitch_nopulse", (vcnt - v0) + (fcnt - f0), 0);
    send_frame(8'h3C, 1'b1, BIT);
    drive(1'b1, 50);
    chk("post_glitch_valid", vcnt - v0, 1);
    chk("post_glitch_data", int'(oRXDATA), 'h3C);

    // framing error with the line then held low (break)
    v0 = vcnt; f0 = fcnt;
    send_frame(8'hFF, 1'b0, BIT);
    drive(1'b0, BIT);
    chk("ferr_pulse", fcnt - f0, 1);
    chk("ferr_novalid", vcnt - v0, 0);
    chk("ferr_data_held", int'(oRXDATA), 'h3C);
    chk("break_no_retrigger", int'(oSTATE), 0);
    drive(1'b1, 2 * BIT);
    chk("break_idle_after_rise", int'(oSTATE), 0);

    // reset during bit 4 of 0x81
    v0 = vcnt; f0 = fcnt;
    drive(1'b0, BIT);
    for (int b = 0; b < 4; b++) drive(b == 0, BIT);
    drive(1'b0, 200);
    chk("pre_reset_busy", int'(oRXBUSY), 1);
    iRESET = 1'b1;
    #1;
    chk("midrst_data",  int'(oRXDATA), 0);
    chk("midrst_busy",  int'(oRXBUSY), 0);
    chk("midrst_state", int'(oSTATE), 0);
    chk("midrst_pulses", int'(oRXVALID) + int'(oFRAMEERR), 0);
    repeat (3) @(negedge iCLOCK);
    iRX = 1'b1;
    repeat (3) @(negedge iCLOCK);
    iRESET = 1'b0;
    drive(1'b1, BIT);
    chk("rst_exit_nopulse", (vcnt - v0) + (fcnt - f0), 0);
    send_frame(8'h42, 1'b1, BIT);
    drive(1'b1, 50);
    chk("post_rst_valid", vcnt - v0, 1);
    chk("post_rst_data", int'(oRXDATA), 'h42);

    // random burst, short random gaps
    rxq.delete();
    v0 = vcnt;
    for (int i = 0; i < 5; i++) begin
      rnd[i] = 8'($urandom_range(0, 255));
      send_frame(rnd[i], 1'b1, BIT);
      drive(1'b1, 1 + $urandom_range(0, 40));
    end
    drive(1'b1, 50);
    chk("rand_count", vcnt - v0, 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rand_d%0d", i), rxq.size() > 0 ? int'(rxq.pop_front()) : -1, int'(rnd[i]));

    chk("valid_ferr_exclusive", both, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
